// File: rtl/pf_ddr4_phy_pkg.sv
// rtl/pf_ddr4_phy_pkg.sv - shared types and defaults for the PF DDR4 IOD delay-line controller
package pf_ddr4_phy_pkg;

  localparam int unsigned DEF_TAP_W         = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_MAX_TAP       = 255;
  localparam int unsigned DEF_LOAD_TAP      = 1;

  typedef enum logic [1:0] {
    DLY_NOP  = 2'b00,
    DLY_LOAD = 2'b01,
    DLY_INC  = 2'b10,
    DLY_DEC  = 2'b11
  } dly_op_e;

  typedef logic [2:0] dly_state_e;

  localparam dly_state_e ST_IDLE   = 3'd0;
  localparam dly_state_e ST_SETUP  = 3'd1;
  localparam dly_state_e ST_PULSE  = 3'd2;
  localparam dly_state_e ST_SETTLE = 3'd3;
  localparam dly_state_e ST_FIN    = 3'd4;

endpackage

// File: rtl/pf_ddr4_iod_dly_ctrl.sv
// rtl/pf_ddr4_iod_dly_ctrl.sv - sequences LOAD/MOVE pulses on one PF IOD dynamic delay line
module pf_ddr4_iod_dly_ctrl
  import pf_ddr4_phy_pkg::*;
#(
  parameter int unsigned TAP_W         = DEF_TAP_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned MAX_TAP       = DEF_MAX_TAP,
  parameter int unsigned LOAD_TAP      = DEF_LOAD_TAP
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [1:0]       REQ_OP,
  input  logic [TAP_W-1:0] REQ_STEPS,
  output logic             DONE,
  output logic             ERR_OOR,
  output logic [TAP_W-1:0] TAP_COUNT,
  output logic             DELAY_LINE_LOAD,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  input  logic             DELAY_LINE_OUT_OF_RANGE
);

  localparam int unsigned      CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] MAX_TAP_W   = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] LOAD_TAP_W  = TAP_W'(LOAD_TAP);
  localparam logic [TAP_W-1:0] ONE_TAP     = TAP_W'(1);

  dly_state_e       state_q, state_d;
  dly_op_e          op_q, op_d;
  logic [TAP_W-1:0] steps_q, steps_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic             move_q, move_d;
  logic             load_q, load_d;
  logic             done_q, done_d;
  logic             limit_hit;

  // Another step in the current direction would walk the tap past either end of the line.
  assign limit_hit = ((op_q == DLY_INC) && (tap_q == MAX_TAP_W)) ||
                     ((op_q == DLY_DEC) && (tap_q == '0));

  // Request sequencing: decide pulse vs. finish at SETUP and at the last settle cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    steps_d = steps_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_VALID) begin
          op_d    = dly_op_e'(REQ_OP);
          steps_d = REQ_STEPS;
          dir_d   = (dly_op_e'(REQ_OP) == DLY_INC);
          err_d   = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (op_q == DLY_LOAD) begin
          state_d = ST_PULSE;
        end else if ((op_q == DLY_NOP) || (steps_q == '0)) begin
          state_d = ST_FIN;
        end else if (limit_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        case (op_q)
          DLY_LOAD: tap_d = LOAD_TAP_W;
          DLY_INC:  tap_d = tap_q + ONE_TAP;
          DLY_DEC:  tap_d = tap_q - ONE_TAP;
          default:  tap_d = tap_q;
        endcase
        steps_d = (op_q == DLY_LOAD) ? '0 : steps_q - ONE_TAP;
        cnt_d   = SETTLE_LAST;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (DELAY_LINE_OUT_OF_RANGE) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else if ((op_q == DLY_LOAD) || (steps_q == '0)) begin
          state_d = ST_FIN;
        end else if (limit_hit) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          state_d = ST_PULSE;
        end
      end
      ST_FIN: begin
        dir_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        dir_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // IOD strobes and DONE are registered off the next state so the pins never glitch.
  always_comb begin
    move_d = (state_d == ST_PULSE) && (op_q != DLY_LOAD);
    load_d = (state_d == ST_PULSE) && (op_q == DLY_LOAD);
    done_d = (state_d == ST_FIN);
  end

  // State and output registers; reset aborts any request in flight immediately.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q <= ST_IDLE;
      op_q    <= DLY_NOP;
      steps_q <= '0;
      tap_q   <= LOAD_TAP_W;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      move_q  <= 1'b0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      steps_q <= steps_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
      move_q  <= move_d;
      load_q  <= load_d;
      done_q  <= done_d;
    end
  end

  assign REQ_READY            = (state_q == ST_IDLE);
  assign DONE                 = done_q;
  assign ERR_OOR              = err_q;
  assign TAP_COUNT            = tap_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_pf_ddr4_iod_dly_ctrl.sv
// tb/tb_pf_ddr4_iod_dly_ctrl.sv - scoreboard bench for the IOD delay-line controller
module tb_pf_ddr4_iod_dly_ctrl;

  localparam int S    = 4;
  localparam int MAXT = 255;
  localparam int LT   = 1;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [1:0] REQ_OP = 2'b00;
  logic [7:0] REQ_STEPS = 8'd0;
  logic       DONE;
  logic       ERR_OOR;
  logic [7:0] TAP_COUNT;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;

  pf_ddr4_iod_dly_ctrl #(
    .TAP_W(8), .SETTLE_CYCLES(S), .MAX_TAP(MAXT), .LOAD_TAP(LT)
  ) dut (
    .FAB_CLK(FAB_CLK),
    .ARST_N(ARST_N),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP),
    .REQ_STEPS(REQ_STEPS),
    .DONE(DONE),
    .ERR_OOR(ERR_OOR),
    .TAP_COUNT(TAP_COUNT),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    int op;
    int latency;
    int npulses;
    int tap;
    int err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_tap = LT;
  int   oor_k_cur = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: walk the request one tap at a time; stop on a line end or on IOD out-of-range.
  function automatic exp_t model(input int op, input int n, input int oor_k, input int tap_in);
    exp_t e;
    int   t;
    t = tap_in;
    e.op = op;
    e.err = 0;
    e.npulses = 0;
    e.latency = 2;
    if (op == 1) begin
      e.npulses = 1;
      t = LT;
      e.latency = 3 + S;
    end else if (op >= 2) begin
      for (int i = 0; i < n; i++) begin
        if ((op == 2 && t == MAXT) || (op == 3 && t == 0)) begin
          e.err = 1;
          break;
        end
        e.npulses++;
        t = (op == 2) ? t + 1 : t - 1;
        if (oor_k != 0 && e.npulses >= oor_k) begin
          e.err = 1;
          break;
        end
      end
      e.latency = 2 + e.npulses * (1 + S);
    end
    e.tap = t;
    return e;
  endfunction

  // IOD model: raise OUT_OF_RANGE once the chosen number of moves has been seen.
  int iod_moves = 0;
  always @(negedge FAB_CLK) begin
    if (!ARST_N) begin
      iod_moves = 0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
    end else if (REQ_VALID && REQ_READY) begin
      iod_moves = 0;
      DELAY_LINE_OUT_OF_RANGE = 1'b0;
    end else if (DELAY_LINE_MOVE) begin
      iod_moves++;
      if (oor_k_cur != 0 && iod_moves >= oor_k_cur) DELAY_LINE_OUT_OF_RANGE = 1'b1;
    end
  end

  // Monitor: observe pulses per request and compare against the queued expectation at DONE.
  bit   mon_busy = 0;
  int   mon_acc = 0;
  int   mon_pulses = 0;
  bit   mon_timing_ok, mon_kind_ok, mon_dir_ok, mon_ready_ok;
  logic mon_dir_prev = 1'b0;
  exp_t mon_e;
  always @(negedge FAB_CLK) begin
    int off;
    cyc++;
    if (!ARST_N) begin
      mon_busy = 0;
    end else begin
      if (mon_busy && sb_q.size() == 0) mon_busy = 0;
      if (mon_busy) begin
        mon_e = sb_q[0];
        off = cyc - mon_acc;
        if (off == 1) begin
          chk("dir_at_setup", DELAY_LINE_DIRECTION, (mon_e.op == 2));
          chk("err_cleared_on_accept", ERR_OOR, 0);
        end
        if (REQ_READY) mon_ready_ok = 0;
        if (DELAY_LINE_MOVE || DELAY_LINE_LOAD) begin
          if (off != 2 + mon_pulses * (1 + S)) mon_timing_ok = 0;
          if (DELAY_LINE_MOVE && DELAY_LINE_LOAD) mon_kind_ok = 0;
          if (DELAY_LINE_LOAD != (mon_e.op == 1)) mon_kind_ok = 0;
          if (DELAY_LINE_MOVE && ((DELAY_LINE_DIRECTION != (mon_e.op == 2)) ||
                                  (mon_dir_prev != DELAY_LINE_DIRECTION))) mon_dir_ok = 0;
          mon_pulses++;
        end
        if (DONE) begin
          void'(sb_q.pop_front());
          chk("done_latency", off, mon_e.latency);
          chk("pulse_count", mon_pulses, mon_e.npulses);
          chk("pulse_timing", mon_timing_ok, 1);
          chk("pulse_kind", mon_kind_ok, 1);
          chk("move_direction", mon_dir_ok, 1);
          chk("dir_hold_fin", DELAY_LINE_DIRECTION, (mon_e.op == 2));
          chk("ready_low_busy", mon_ready_ok, 1);
          chk("tap_count", TAP_COUNT, mon_e.tap);
          chk("err_oor", ERR_OOR, mon_e.err);
          mon_busy = 0;
        end
      end else if (DONE) begin
        chk("unexpected_done", DONE, 0);
      end
      if (REQ_VALID && REQ_READY) begin
        mon_busy = 1;
        mon_acc = cyc;
        mon_pulses = 0;
        mon_timing_ok = 1;
        mon_kind_ok = 1;
        mon_dir_ok = 1;
        mon_ready_ok = 1;
      end
    end
    mon_dir_prev = DELAY_LINE_DIRECTION;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, REQ_READY, 1);
    chk({tag, "_tap"}, TAP_COUNT, LT);
    chk({tag, "_move"}, DELAY_LINE_MOVE, 0);
    chk({tag, "_load"}, DELAY_LINE_LOAD, 0);
    chk({tag, "_dir"}, DELAY_LINE_DIRECTION, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_err"}, ERR_OOR, 0);
  endtask

  task automatic issue(input int op, input int n, input int oor_k);
    exp_t e;
    int   g;
    g = 0;
    while (!REQ_READY && g < 200) begin
      @(posedge FAB_CLK); #1;
      g++;
    end
    e = model(op, n, oor_k, m_tap);
    m_tap = e.tap;
    oor_k_cur = oor_k;
    sb_q.push_back(e);
    REQ_OP = op[1:0];
    REQ_STEPS = n[7:0];
    REQ_VALID = 1'b1;
    @(posedge FAB_CLK); #1;
    REQ_VALID = 1'b0;
    REQ_OP = 2'($urandom);
    REQ_STEPS = 8'($urandom);
    g = 0;
    while (sb_q.size() != 0 && g < e.latency + 20) begin
      @(posedge FAB_CLK); #1;
      g++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    int   g;
    int   op, n, k;
    repeat (3) @(posedge FAB_CLK);
    #1;
    check_reset_outputs("in_reset");
    ARST_N = 1'b1;
    @(posedge FAB_CLK); #1;
    check_reset_outputs("after_reset");

    issue(2, 3, 0);
    issue(2, 36, 0);
    issue(1, 0, 0);
    issue(2, 1, 0);
    issue(3, 5, 0);
    issue(1, 9, 0);
    issue(2, 10, 2);

    // Asynchronous reset in the middle of a multi-step INC.
    e = model(2, 10, 0, m_tap);
    sb_q.push_back(e);
    oor_k_cur = 0;
    REQ_OP = 2'b10;
    REQ_STEPS = 8'd10;
    REQ_VALID = 1'b1;
    @(posedge FAB_CLK); #1;
    REQ_VALID = 1'b0;
    g = 0;
    while (!DELAY_LINE_MOVE && g < 20) begin
      @(negedge FAB_CLK);
      g++;
    end
    chk("mid_op_move_seen", DELAY_LINE_MOVE, 1);
    @(posedge FAB_CLK); #2;
    ARST_N = 1'b0;
    sb_q.delete();
    m_tap = LT;
    #1;
    check_reset_outputs("mid_op_reset");
    @(negedge FAB_CLK);
    @(posedge FAB_CLK); #1;
    ARST_N = 1'b1;
    issue(2, 1, 0);

    issue(0, 7, 0);
    issue(2, 0, 0);
    issue(3, 0, 0);
    issue(2, 254, 0);
    issue(2, 3, 0);
    issue(3, 2, 0);
    issue(3, 1, 1);

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      n = $urandom_range(0, 12);
      k = ($urandom_range(0, 3) == 0 && op >= 2) ? $urandom_range(1, 3) : 0;
      issue(op, n, k);
    end

    repeat (3) @(posedge FAB_CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
